por_reset_sequencer: RTL and testbench
======================================

Name: por_reset_sequencer

Overview:
- Consumes the raw power-on-reset level `porb_l_i` from the POR block, which is asynchronous to the system clock.
- Synchronizes and debounces it, then releases NUM_DOM downstream reset domains one at a time.
- Each release waits for a per-domain ready handshake, then a programmable gap, before the next domain is released.
- Sits between the POR macro and the housekeeping, PLL, and core reset inputs. It also services a software-initiated full re-sequence.

Parameters:
- NUM_DOM, 3, number of sequenced reset domains; index 0 is released first.
- STABLE_CYC, 16, consecutive synchronized-high cycles of porb required before sequencing starts.
- GAP_CYC, 8, idle cycles inserted after each domain's ready before the next release.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(STABLE_CYC, GAP_CYC, TIMEOUT_CYC).
- TIMEOUT_CYC, 200, ready-wait limit per domain; used only with READY_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- porb_l_i  in  1  POR output, active-low, asynchronous.
- sw_rst_req_i  in  1  single-cycle pulse requesting a full re-sequence.
- dom_ready_i  in  NUM_DOM  per-domain ready (e.g. PLL lock); level, treated as synchronous.
- rst_dom_o  out  NUM_DOM  per-domain reset, active-high, registered.
- seq_done_o  out  1  high while all domains are released and RUN is active.
- seq_state_o  out  3  current FSM state encoding, for debug/housekeeping readback.
- timeout_err_o  out  1  sticky error flag; tied 0 when READY_TIMEOUT_EN is undefined.

Behaviour:
- Reset (wb_rst_i=1, sampled on a wb_clk_i edge):
  - FSM goes to HOLD.
  - rst_dom_o = all 1s; seq_done_o = 0; timeout_err_o = 0.
  - Synchronizer flops = 0; counters = 0; domain index = 0.
- porb_l_i passes through a 2-flop synchronizer giving `porb_s`, which adds 2 cycles of latency.
- States:
  - HOLD: waits for porb_s=1, then → DEBOUNCE with cnt cleared.
  - DEBOUNCE: cnt increments on each cycle with porb_s=1. Any cycle with porb_s=0 clears cnt and returns to HOLD. When cnt reaches STABLE_CYC-1 → RELEASE.
  - RELEASE: deasserts rst_dom_o[idx] (one cycle here), then → WAIT_RDY.
  - WAIT_RDY: when dom_ready_i[idx]=1 → GAP with cnt cleared.
  - GAP: counts GAP_CYC cycles. On expiry, if idx = NUM_DOM-1 → RUN; otherwise idx increments and → RELEASE.
  - RUN: seq_done_o=1; stays until porb_s falls or sw_rst_req_i is pulsed.
- Released domains stay released through later states; rst_dom_o[k] = 0 for all k < idx.
- Latency with all ready inputs already high: porb_l_i rising → rst_dom_o[0] falling is exactly 2 + STABLE_CYC + 1 cycles.
- Brown-out: porb_s=0 in any state other than HOLD re-asserts all rst_dom_o on the next edge, clears idx and seq_done_o, and → HOLD. This takes priority over sw_rst_req_i and over all counters.
- sw_rst_req_i in any state except HOLD/DEBOUNCE re-asserts all rst_dom_o, clears idx, and → DEBOUNCE with cnt cleared (porb is known good).
- sw_rst_req_i during HOLD/DEBOUNCE is ignored.
- Simultaneous porb_s fall and sw_rst_req_i: brown-out wins.
- A dom_ready_i that drops after its domain is released is ignored; it is not re-checked.
- seq_done_o is registered and equals (state==RUN).
- seq_state_o encoding: HOLD=0, DEBOUNCE=1, RELEASE=2, WAIT_RDY=3, GAP=4, RUN=5.

Optional Feature:
- Macro: READY_TIMEOUT_EN.
- When defined:
  - WAIT_RDY counts cycles. If dom_ready_i[idx] is still 0 after TIMEOUT_CYC cycles, timeout_err_o latches 1 and the FSM proceeds to GAP as if ready.
  - timeout_err_o clears only on wb_rst_i or a brown-out.
- When undefined: WAIT_RDY waits indefinitely; timeout_err_o is constant 0 and no timeout logic is generated.

Decomposition:
- Shared package `por_seq_pkg`:
  - State enum and encodings (3-bit).
  - Default parameter constants: STABLE_CYC, GAP_CYC, TIMEOUT_CYC.
- One sub-module, `por_sync_2ff`:
  - 2-flop synchronizer with a synchronous active-high clear; reusable elsewhere.
  - Instantiated once, for porb_l_i.

Test Plan:
- Clean power-up, NUM_DOM=3, STABLE_CYC=16, GAP_CYC=8, dom_ready_i=3'b111, porb_l_i rises at cycle 0:
  - rst_dom_o[0] falls at cycle 19, rst_dom_o[1] at 29, rst_dom_o[2] at 39.
  - seq_done_o rises at cycle 48.
- Glitchy POR: porb_l_i high for 10 cycles, low for 1, then high:
  - No domain is released during the glitch.
  - rst_dom_o[0] falls 19 cycles after the final rise.
- Ready stall: dom_ready_i[1] held 0 for 50 cycles after domain 1's release:
  - rst_dom_o[2] stays 1 until dom_ready_i[1] rises plus 9 cycles.
  - seq_state_o=3 throughout the stall.
- Brown-out in RUN: porb_l_i drops:
  - Within 3 cycles, rst_dom_o=3'b111, seq_done_o=0, seq_state_o=0.
- sw_rst_req_i pulse in RUN:
  - Next cycle, rst_dom_o=3'b111 and seq_state_o=1.
  - Full re-sequence completes; the release pattern matches the first scenario, offset to DEBOUNCE entry (domain 0 releases 17 cycles after the pulse).
- With READY_TIMEOUT_EN, TIMEOUT_CYC=200, dom_ready_i[0] stuck at 0:
  - timeout_err_o=1 after 200 WAIT_RDY cycles; sequencing continues to RUN.
  - wb_rst_i clears timeout_err_o.

Source files
------------

// File: rtl/por_seq_pkg.sv
// Shared state encoding and default timing constants for the POR reset sequencer.
package por_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_GAP      = 3'd4,
        ST_RUN      = 3'd5
    } seq_state_e;

    localparam int STABLE_CYC_DEF  = 16;
    localparam int GAP_CYC_DEF     = 8;
    localparam int TIMEOUT_CYC_DEF = 200;

endpackage

// File: rtl/por_sync_2ff.sv
// Two-flop level synchronizer with synchronous active-high clear.
module por_sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/por_reset_sequencer.sv
// Debounces the POR level and releases NUM_DOM reset domains in order, each gated by ready + gap.
// Optional ready-wait timeout with sticky error flag: define READY_TIMEOUT_EN.
module por_reset_sequencer
    import por_seq_pkg::*;
#(
    parameter int NUM_DOM     = 3,
    parameter int STABLE_CYC  = STABLE_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               porb_l_i,
    input  logic               sw_rst_req_i,
    input  logic [NUM_DOM-1:0] dom_ready_i,
    output logic [NUM_DOM-1:0] rst_dom_o,
    output logic               seq_done_o,
    output logic [2:0]         seq_state_o,
    output logic               timeout_err_o
);

    localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int CNT_MAX = (STABLE_CYC > GAP_CYC)
                             ? ((STABLE_CYC > TIMEOUT_CYC) ? STABLE_CYC : TIMEOUT_CYC)
                             : ((GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_CAP     = CNT_W'(CNT_MAX - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOM - 1);

    seq_state_e         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [NUM_DOM-1:0] rst_nx;
    logic               porb_s;

    por_sync_2ff u_porb_sync (
        .clk (wb_clk_i),
        .clr (wb_rst_i),
        .d   (porb_l_i),
        .q   (porb_s)
    );

    // Counter saturates at the largest threshold in use so it can never wrap.
    assign cnt_inc     = (cnt == CNT_CAP) ? cnt : cnt + 1'b1;
    assign seq_state_o = state;

`ifdef READY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic err_nx;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        rst_nx   = rst_dom_o;
`ifdef READY_TIMEOUT_EN
        err_nx   = timeout_err_o;
`endif
        // Brown-out beats everything, including a software request in the same cycle.
        if (state != ST_HOLD && !porb_s) begin
            state_nx = ST_HOLD;
            cnt_nx   = '0;
            idx_nx   = '0;
            rst_nx   = '1;
`ifdef READY_TIMEOUT_EN
            err_nx   = 1'b0;
`endif
        end else if (sw_rst_req_i && state != ST_HOLD && state != ST_DEBOUNCE) begin
            state_nx = ST_DEBOUNCE;
            cnt_nx   = '0;
            idx_nx   = '0;
            rst_nx   = '1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (porb_s) begin
                        state_nx = ST_DEBOUNCE;
                        cnt_nx   = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (cnt == STABLE_LAST) begin
                        state_nx = ST_RELEASE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    rst_nx[idx] = 1'b0;
                    state_nx    = ST_WAIT_RDY;
                    cnt_nx      = '0;
                end
                ST_WAIT_RDY: begin
                    if (dom_ready_i[idx]) begin
                        state_nx = ST_GAP;
                        cnt_nx   = '0;
                    end
`ifdef READY_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        err_nx   = 1'b1;
                        state_nx = ST_GAP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nx = '0;
                        if (idx == IDX_LAST) begin
                            state_nx = ST_RUN;
                        end else begin
                            idx_nx   = idx + 1'b1;
                            state_nx = ST_RELEASE;
                        end
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                ST_RUN: begin
                    state_nx = ST_RUN;
                end
                default: begin
                    state_nx = ST_HOLD;
                    rst_nx   = '1;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
            rst_dom_o  <= '1;
            seq_done_o <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            rst_dom_o  <= rst_nx;
            seq_done_o <= (state_nx == ST_RUN);
        end
    end

`ifdef READY_TIMEOUT_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            timeout_err_o <= 1'b0;
        end else begin
            timeout_err_o <= err_nx;
        end
    end
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Bench for por_reset_sequencer: vector table, hand-written corner sequences and a timestamp-based random model.
module tb_por_reset_sequencer;

    localparam int ND     = 3;
    localparam int STABLE = 16;
    localparam int GAP    = 8;
    localparam int TMO    = 200;

    logic          clk    = 1'b0;
    logic          rst_in = 1'b1;
    logic          porb   = 1'b0;
    logic          sw     = 1'b0;
    logic [ND-1:0] rdy    = '1;
    logic [ND-1:0] rst_dom;
    logic          done;
    logic [2:0]    st;
    logic          err;

    always #5 clk = ~clk;

    por_reset_sequencer #(
        .NUM_DOM     (ND),
        .STABLE_CYC  (STABLE),
        .GAP_CYC     (GAP),
        .CNT_W       (8),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst_in),
        .porb_l_i      (porb),
        .sw_rst_req_i  (sw),
        .dom_ready_i   (rdy),
        .rst_dom_o     (rst_dom),
        .seq_done_o    (done),
        .seq_state_o   (st),
        .timeout_err_o (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks when sequencing began and when each domain falls/sees ready,
    // then derives outputs from those timestamps.
    bit            ms1 = 0, ms2 = 0;
    bit            mheld = 1;
    int            mn = 0;
    int            mt_deb = 0, mt_fall = 0, mt_rdy = -1, mdom = 0;
    logic [ND-1:0] mrst = '1;
    bit            mdone = 0, merr = 0;

    task automatic start_seq();
        mt_deb  = mn;
        mdom    = 0;
        mt_fall = mn + STABLE + 1;
        mt_rdy  = -1;
        mrst    = '1;
        mdone   = 0;
    endtask

    task automatic model_step();
        bit p;
        p = ms2;
        mn++;
        if (rst_in) begin
            ms1 = 0; ms2 = 0; mheld = 1; mrst = '1; mdone = 0; merr = 0;
            return;
        end
        ms2 = ms1;
        ms1 = porb;
        if (!p) begin
            mheld = 1; mrst = '1; mdone = 0; merr = 0;
            return;
        end
        if (mheld) begin
            mheld = 0;
            start_seq();
            return;
        end
        if (sw && mn > mt_deb + STABLE) begin
            start_seq();
            return;
        end
        if (mdone) return;
        if (mn == mt_fall) begin
            mrst[mdom] = 1'b0;
        end else if (mn > mt_fall && mt_rdy < 0) begin
            if (rdy[mdom]) mt_rdy = mn;
`ifdef READY_TIMEOUT_EN
            else if (mn - mt_fall == TMO) begin
                merr   = 1;
                mt_rdy = mn;
            end
`endif
        end else if (mt_rdy >= 0 && mn == mt_rdy + GAP) begin
            if (mdom == ND - 1) begin
                mdone = 1;
            end else begin
                mdom++;
                mt_fall = mn + 1;
                mt_rdy  = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_rst", int'(rst_dom), int'(mrst));
        chk("model_done", int'(done), int'(mdone));
        chk("model_err", int'(err), int'(merr));
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        sw     = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic run_until_done(input string nm, input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin
            tick();
            k++;
        end
        chk(nm, int'(done), 1);
    endtask

    typedef struct {
        logic          r;
        logic          p;
        logic          s;
        logic [ND-1:0] rd;
        int            ncyc;
        logic [ND-1:0] e_rst;
        logic          e_done;
        logic [2:0]    e_st;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic p, input logic s, input logic [ND-1:0] rd,
                                input int n, input logic [ND-1:0] er, input logic ed, input logic [2:0] es);
        vec_t v;
        v.r = r; v.p = p; v.s = s; v.rd = rd; v.ncyc = n;
        v.e_rst = er; v.e_done = ed; v.e_st = es;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int  k;
        bit  ok;
        int  drop;

        // Clean power-up; porb first sampled high on the first edge of row 1 (edge k).
        tbl.push_back(mk(1, 0, 0, 3'b111, 3,  3'b111, 0, 3'd0)); // reset state
        tbl.push_back(mk(0, 1, 0, 3'b111, 2,  3'b111, 0, 3'd0)); // k+1 still HOLD
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b111, 0, 3'd1)); // k+2 DEBOUNCE
        tbl.push_back(mk(0, 1, 0, 3'b111, 15, 3'b111, 0, 3'd1)); // k+17
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b111, 0, 3'd2)); // k+18 RELEASE
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b110, 0, 3'd3)); // k+19 dom0 falls
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b110, 0, 3'd4)); // k+20 GAP
        tbl.push_back(mk(0, 1, 0, 3'b111, 8,  3'b110, 0, 3'd2)); // k+28
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b100, 0, 3'd3)); // k+29 dom1 falls
        tbl.push_back(mk(0, 1, 0, 3'b111, 9,  3'b100, 0, 3'd2)); // k+38
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b000, 0, 3'd3)); // k+39 dom2 falls
        tbl.push_back(mk(0, 1, 0, 3'b111, 8,  3'b000, 0, 3'd4)); // k+47
        tbl.push_back(mk(0, 1, 0, 3'b111, 1,  3'b000, 1, 3'd5)); // k+48 RUN
        tbl.push_back(mk(0, 1, 0, 3'b111, 10, 3'b000, 1, 3'd5)); // stays in RUN

        foreach (tbl[i]) begin
            rst_in = tbl[i].r;
            porb   = tbl[i].p;
            sw     = tbl[i].s;
            rdy    = tbl[i].rd;
            repeat (tbl[i].ncyc) tick();
            chk($sformatf("tbl%0d_rst", i), int'(rst_dom), int'(tbl[i].e_rst));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d_state", i), int'(st), int'(tbl[i].e_st));
            if (i == 0) chk("reset_err", int'(err), 0);
        end

        // Brown-out while in RUN.
        porb = 1'b0;
        repeat (3) tick();
        chk("brownout_rst", int'(rst_dom), 7);
        chk("brownout_done", int'(done), 0);
        chk("brownout_state", int'(st), 0);

        // Glitchy POR: 10 high, 1 low, then high for good.
        ok = 1;
        porb = 1'b1;
        repeat (10) begin tick(); if (rst_dom != 3'b111) ok = 0; end
        porb = 1'b0;
        tick();
        if (rst_dom != 3'b111) ok = 0;
        porb = 1'b1;
        repeat (19) begin tick(); if (rst_dom != 3'b111) ok = 0; end
        chk("glitch_no_release", int'(ok), 1);
        tick();
        chk("glitch_rel0", int'(rst_dom), 6);
        run_until_done("glitch_run", 100);

        // Software re-sequence from RUN, with a second request during DEBOUNCE that must be ignored.
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("sw_rst", int'(rst_dom), 7);
        chk("sw_state", int'(st), 1);
        repeat (4) tick();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        repeat (10) tick();
        chk("sw_deb_state", int'(st), 1);
        tick();
        chk("sw_release_state", int'(st), 2);
        chk("sw_release_rst", int'(rst_dom), 7);
        tick();
        chk("sw_rel0", int'(rst_dom), 6);
        repeat (28) tick();
        chk("sw_done_early", int'(done), 0);
        tick();
        chk("sw_done", int'(done), 1);

        // Ready stall on domain 1.
        do_reset();
        rdy  = 3'b101;
        porb = 1'b1;
        k = 0;
        while (rst_dom != 3'b100 && k < 100) begin tick(); k++; end
        chk("stall_rel1", int'(rst_dom), 4);
        ok = 1;
        repeat (50) begin tick(); if (st != 3'd3 || rst_dom[2] != 1'b1) ok = 0; end
        chk("stall_wait", int'(ok), 1);
        rdy = 3'b111;
        repeat (9) tick();
        chk("stall_hold2", int'(rst_dom[2]), 1);
        tick();
        chk("stall_rel2", int'(rst_dom[2]), 0);
        run_until_done("stall_run", 100);

        // Brown-out and software request seen on the same edge: brown-out wins.
        porb = 1'b0;
        tick();
        tick();
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("bo_vs_sw_state", int'(st), 0);
        chk("bo_vs_sw_rst", int'(rst_dom), 7);
        porb = 1'b1;

`ifdef READY_TIMEOUT_EN
        // Domain 0 never becomes ready: timeout after TMO cycles, then sequencing continues.
        do_reset();
        rdy  = 3'b110;
        porb = 1'b1;
        repeat (19 + TMO) tick();
        chk("tmo_err_before", int'(err), 0);
        chk("tmo_wait_state", int'(st), 3);
        tick();
        chk("tmo_err_set", int'(err), 1);
        run_until_done("tmo_run", 100);
        chk("tmo_err_sticky", int'(err), 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("tmo_err_clear", int'(err), 0);
`endif

        // Randomized traffic against the timestamp model.
        do_reset();
        drop = 0;
        for (int i = 0; i < 4000; i++) begin
            if (drop > 0) begin
                porb = 1'b0;
                drop--;
            end else begin
                porb = 1'b1;
                if ($urandom_range(0, 299) == 0) drop = int'($urandom_range(1, 5));
            end
            sw     = ($urandom_range(0, 119) == 0);
            rst_in = ($urandom_range(0, 1499) == 0);
            for (int b = 0; b < ND; b++) rdy[b] = ($urandom_range(0, 7) != 0);
            tick();
        end
        rst_in = 1'b0;
        sw     = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
